layer_stream_sequencer: RTL
===========================

// Module: layer_stream_sequencer
// PURPOSE
//  Sequences one fully-parallel neuron layer into the serial input of the next layer.
//  - Collects the nn per-neuron results (each neuron's outvalid pulse arrives independently).
//  - Once all nn are held, replays them one per accepted beat as an x_valid/x_in stream.
//  - Sits between layer N's outvalid/flat-output bus and layer N+1's x_valid/x_in.
// PARAMETERS
//  nn          30  neurons in the producing layer = elements per output stream
//  data_width  16  bits per neuron result
// PORTS
//  clk          in   1              single clock, all logic rising-edge
//  rst          in   1              synchronous reset, active-low (0 = reset)
//  in_valid     in   nn             per-neuron result-valid pulses (bit i = neuron i)
//  in_data_flat in   nn*data_width  neuron i result at [i*data_width +: data_width]
//  out_ready    in   1              downstream accepts the current beat
//  x_valid      out  1              stream beat valid
//  x_out        out  data_width     stream beat data
//  busy         out  1              1 while streaming
//  layer_done   out  1              1-cycle pulse on acceptance of the final beat
//  overrun      out  1              sticky: in_valid bit seen while streaming
// BEHAVIOUR
//  Reset (rst==0 at clk edge):
//  - Outputs: x_valid=0, x_out=0, busy=0, layer_done=0, overrun=0.
//  - Internal: got mask=0, idx=0, FSM=COLLECT. Data buffer contents don't care.
//  - Reset mid-stream abandons the stream; the next beat appears only after a full new collection.
//  FSM COLLECT:
//  - For every i with in_valid[i]=1: buf[i] <= slice i; got[i] <= 1.
//  - Repeat pulse for an already-got i overwrites buf[i]; no error.
//  - When (got | in_valid) == all-ones: go STREAM next edge, idx <= 0, got <= 0,
//    x_valid <= 1, x_out <= element 0 (the same-cycle slice if it arrived this cycle).
//  - Latency: last missing pulse at edge T -> x_valid=1 with element 0 after edge T+1.
//    All neurons valid in one cycle -> same single-cycle latency.
//  FSM STREAM:
//  - busy=1; x_valid=1; x_out=buf[idx]. x_out and x_valid are registered outputs.
//  - Beat accepted when x_valid & out_ready.
//  - Accept with idx<nn-1: idx++, x_out <= buf[idx+1] on the same edge.
//    Back-to-back beats at full rate.
//  - out_ready=0: hold x_out/x_valid/idx stable, with no limit on stall length.
//  - Accept with idx==nn-1: x_valid <= 0, busy <= 0, layer_done <= 1 for one cycle, go COLLECT.
//  - Any in_valid bit in STREAM: data ignored (buffer untouched, got untouched), overrun <= 1.
//    Sticky until reset.
//  - In_valid in the cycle of the final accept still counts as STREAM -> overrun. Not collected.
//  Widths:
//  - idx width = $clog2(nn), min 1. No arithmetic on data; bit-exact pass-through.
//  - nn=1 valid: single-beat stream, layer_done on that accept.
// TESTING
//  1 Reset: rst=0 for 2 cycles with random in_valid -> all outputs 0, no x_valid for 3 cycles after release.
//  2 nn=30, dw=16: pulse neuron i with data 0x0100+i, one per cycle, order 29..0.
//    -> x_valid 1 cycle after last pulse; x_out 0x0100..0x011D in order with out_ready=1.
//    -> layer_done pulse with the beat 0x011D.
//  3 All 30 in_valid in one cycle, out_ready toggling 1,0,1,0 -> each value held across stalls.
//    -> exactly 30 accepts, no duplicates/skips.
//  4 Pulse neuron 5 with 0xAAAA then 0x5555 before completing the set -> stream element 5 = 0x5555.
//  5 in_valid[3] while streaming beat 10 -> overrun=1 and stays 1.
//    -> remaining beats unchanged; next collection still needs all 30 pulses.
//  6 rst=0 at beat 12 of a stream -> x_valid drops next edge.
//    -> fresh 30-pulse set streams from element 0 with new values.

Source files
------------

// File: rtl/layer_stream_sequencer.sv
// ---------------------------------------------------------------------------
// layer_stream_sequencer
//
// Purpose:
//   This block connects one fully-parallel neuron layer to the serial input of
//   the next layer. It collects the nn per-neuron results. Each result arrives
//   on its own in_valid pulse. Once every neuron has reported, the block
//   replays the results in order, one result per accepted beat, on an
//   x_valid / x_out stream.
//
// Ports:
//   clk           in   1               single clock, rising edge
//   rst           in   1               synchronous reset, active-low
//   in_valid      in   nn              per-neuron result-valid pulses
//   in_data_flat  in   nn*data_width   neuron i result at [i*data_width +: data_width]
//   out_ready     in   1               downstream accepts the current beat
//   x_valid       out  1               stream beat valid (registered)
//   x_out         out  data_width      stream beat data (registered)
//   busy          out  1               high while streaming (registered)
//   layer_done    out  1               one-cycle pulse after the final beat is accepted
//   overrun       out  1               sticky: a result arrived while streaming
// ---------------------------------------------------------------------------
module layer_stream_sequencer #(
    parameter int nn         = 30,
    parameter int data_width = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [nn-1:0]              in_valid,
    input  logic [nn*data_width-1:0]   in_data_flat,
    input  logic                       out_ready,
    output logic                       x_valid,
    output logic [data_width-1:0]      x_out,
    output logic                       busy,
    output logic                       layer_done,
    output logic                       overrun
);

    localparam int idx_w = (nn > 1) ? $clog2(nn) : 1;
    localparam logic [idx_w-1:0] last_idx = idx_w'(nn - 1);
    localparam logic [nn-1:0]    all_ones = {nn{1'b1}};

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        STREAM  = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [nn-1:0]          got_r;
    logic [nn-1:0]          got_next_s;
    logic [idx_w-1:0]       idx_r;
    logic [idx_w-1:0]       idx_next_s;
    logic [idx_w-1:0]       idx_inc_s;
    logic                   x_valid_r;
    logic                   x_valid_next_s;
    logic [data_width-1:0]  x_out_r;
    logic [data_width-1:0]  x_out_next_s;
    logic                   busy_r;
    logic                   busy_next_s;
    logic                   layer_done_r;
    logic                   layer_done_next_s;
    logic                   overrun_r;
    logic                   overrun_next_s;
    logic [nn-1:0]          got_merged_s;
    logic [data_width-1:0]  first_elem_s;
    logic                   accept_s;

    // The result buffer needs no reset. Its contents are never read before a
    // full collection has overwritten every entry.
    logic [data_width-1:0]  buf_r [0:nn-1];

    assign x_valid    = x_valid_r;
    assign x_out      = x_out_r;
    assign busy       = busy_r;
    assign layer_done = layer_done_r;
    assign overrun    = overrun_r;

    // Capture the incoming neuron results into the buffer, but only while collecting.
    always_ff @(posedge clk) begin
        for (int i = 0; i < nn; i++) begin
            if ((state_r == COLLECT) && in_valid[i]) begin
                buf_r[i] <= in_data_flat[i*data_width +: data_width];
            end
        end
    end

    // Compute the next-state and next-output values for the sequencer FSM.
    always_comb begin
        next_state_s      = state_r;
        got_next_s        = got_r;
        idx_next_s        = idx_r;
        x_valid_next_s    = x_valid_r;
        x_out_next_s      = x_out_r;
        busy_next_s       = busy_r;
        layer_done_next_s = 1'b0;
        overrun_next_s    = overrun_r;
        got_merged_s      = got_r | in_valid;
        idx_inc_s         = idx_r + idx_w'(1);
        accept_s          = x_valid_r & out_ready;
        // Element 0 may arrive in the same cycle that completes the set. The
        // buffer write has not landed yet, so the input slice takes precedence.
        if (in_valid[0]) begin
            first_elem_s = in_data_flat[data_width-1:0];
        end else begin
            first_elem_s = buf_r[0];
        end

        case (state_r)
            COLLECT: begin
                if (got_merged_s == all_ones) begin
                    next_state_s   = STREAM;
                    got_next_s     = '0;
                    idx_next_s     = '0;
                    x_valid_next_s = 1'b1;
                    x_out_next_s   = first_elem_s;
                    busy_next_s    = 1'b1;
                end else begin
                    got_next_s     = got_merged_s;
                end
            end
            STREAM: begin
                // A result that arrives during playback is dropped. The error is recorded and stays set.
                if (|in_valid) begin
                    overrun_next_s = 1'b1;
                end else begin
                    overrun_next_s = overrun_r;
                end
                if (accept_s) begin
                    if (idx_r == last_idx) begin
                        next_state_s      = COLLECT;
                        idx_next_s        = '0;
                        x_valid_next_s    = 1'b0;
                        busy_next_s       = 1'b0;
                        layer_done_next_s = 1'b1;
                    end else begin
                        idx_next_s   = idx_inc_s;
                        x_out_next_s = buf_r[idx_inc_s];
                    end
                end else begin
                    // Stall: every stream register holds its value.
                    idx_next_s = idx_r;
                end
            end
            default: begin
                next_state_s   = COLLECT;
                got_next_s     = '0;
                idx_next_s     = '0;
                x_valid_next_s = 1'b0;
                busy_next_s    = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs, with a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= COLLECT;
            got_r        <= '0;
            idx_r        <= '0;
            x_valid_r    <= 1'b0;
            x_out_r      <= '0;
            busy_r       <= 1'b0;
            layer_done_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            got_r        <= got_next_s;
            idx_r        <= idx_next_s;
            x_valid_r    <= x_valid_next_s;
            x_out_r      <= x_out_next_s;
            busy_r       <= busy_next_s;
            layer_done_r <= layer_done_next_s;
            overrun_r    <= overrun_next_s;
        end
    end

endmodule
